// File: rtl/rv_pkg.sv
// Shared RISC-V front-end constants and the fetch packet type used between
// the fetch unit and its output buffer.
package rv_pkg;

  localparam int unsigned XLEN            = 32;
  localparam logic [31:0] IMEM_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP       = 32'h0000_0013;
  localparam int unsigned FETCH_BUF_DEPTH = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry synchronous FIFO of fetch packets with flush; resets to empty with
// zeroed contents so the head reads as all-zero out of reset.
module fetch_skid_buffer
  import rv_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  fetch_pkt_t pkt_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output fetch_pkt_t head_o,
  output logic [1:0] count_o
);

  fetch_pkt_t mem_q [2];
  logic       rd_ptr_q;
  logic       wr_ptr_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      // Contents are left alone; an empty buffer hides them from the output.
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= pkt_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch initiator: issues word addresses to a one-cycle BRAM,
// buffers returned words and hands {pc, instr} to decode with valid/ready.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = IMEM_RESET_PC,
  parameter int unsigned BUF_DEPTH = FETCH_BUF_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_read_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  logic [31:0] fetch_pc_q;
  logic [31:0] inflight_pc_q;
  logic        inflight_q;
  logic [31:0] redirect_aligned;
  logic [1:0]  count;
  logic [2:0]  occupancy;
  logic        pop;
  logic        push;
  logic        issue;
  fetch_pkt_t  head;
  fetch_pkt_t  ret_pkt;

  assign redirect_aligned = word_align(redirect_pc);

  assign if_valid = (count != 2'd0);
  assign pop      = if_valid & if_ready;

  // Credit: buffered + in flight, minus what leaves this cycle, must leave a
  // free slot for the word requested now.
  assign occupancy = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = 32'(occupancy) < BUF_DEPTH;

  assign imem_addr = redirect_valid ? {2'b00, redirect_pc[31:2]} : {2'b00, fetch_pc_q[31:2]};

  // A return arriving in a redirect cycle belongs to the abandoned path.
  assign push          = inflight_q & ~redirect_valid;
  assign ret_pkt.pc    = inflight_pc_q;
  assign ret_pkt.instr = imem_read_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= '0;
      inflight_q    <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc_q    <= redirect_aligned + 32'd4;
      inflight_pc_q <= redirect_aligned;
      inflight_q    <= 1'b1;
    end else if (issue) begin
      fetch_pc_q    <= fetch_pc_q + 32'd4;
      inflight_pc_q <= fetch_pc_q;
      inflight_q    <= 1'b1;
    end else begin
      inflight_q    <= 1'b0;
    end
  end

  fetch_skid_buffer u_buf (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .pkt_i   (ret_pkt),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .head_o  (head),
    .count_o (count)
  );

  assign if_pc    = head.pc;
  assign if_instr = head.instr;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: one instance at RESET_PC=0 and one
// at the top of the address space, each behind a one-cycle-read BRAM model.
module tb_instr_fetch_unit;
  import rv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance 0: RESET_PC = 0
  logic        rst_n, redirect_valid, if_valid, if_ready;
  logic [31:0] imem_addr, imem_read_data, redirect_pc, if_pc, if_instr;
  logic [31:0] mem0 [16];

  // Instance 1: wrap-around
  logic        w_rst_n, w_if_valid, w_if_ready;
  logic [31:0] w_imem_addr, w_imem_read_data, w_if_pc, w_if_instr;

  fetch_pkt_t q0[$];
  fetch_pkt_t q1[$];
  fetch_pkt_t e0, e1;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_read_data (imem_read_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk            (clk),
    .rst_n          (w_rst_n),
    .imem_addr      (w_imem_addr),
    .imem_read_data (w_imem_read_data),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .if_valid       (w_if_valid),
    .if_ready       (w_if_ready),
    .if_pc          (w_if_pc),
    .if_instr       (w_if_instr)
  );

  // BRAM models: registered read, index by low address bits.
  always @(posedge clk) imem_read_data <= mem0[imem_addr[3:0]];
  always @(posedge clk) w_imem_read_data <= 32'hC0DE_0000 | {28'h0, w_imem_addr[3:0]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic fetch_pkt_t pkt(input logic [31:0] pc, input logic [31:0] instr);
    fetch_pkt_t p;
    p.pc    = pc;
    p.instr = instr;
    return p;
  endfunction

  // Monitors: every accepted beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && if_valid && if_ready) begin
      if (q0.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL beat0 unexpected: got pc %h instr %h expected none", if_pc, if_instr);
      end else begin
        e0 = q0.pop_front();
        chk("beat0 pc", if_pc, e0.pc);
        chk("beat0 instr", if_instr, e0.instr);
      end
    end
  end

  always @(negedge clk) begin
    if (w_rst_n && w_if_valid && w_if_ready) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL beat1 unexpected: got pc %h instr %h expected none", w_if_pc, w_if_instr);
      end else begin
        e1 = q1.pop_front();
        chk("beat1 pc", w_if_pc, e1.pc);
        chk("beat1 instr", w_if_instr, e1.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mem0[0] = 32'h0050_0093;
    mem0[1] = 32'h00A0_0113;
    mem0[2] = 32'h0020_81B3;
    mem0[3] = 32'hDEAD_BEEF;
    mem0[4] = 32'h1234_5678;
    for (int i = 5; i < 16; i++) mem0[i] = 32'h5000_0000 + i;
    rst_n = 1'b0; w_rst_n = 1'b0; if_ready = 1'b0; w_if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(); step();
    chk("reset valid", {31'b0, if_valid}, 32'h0);
    chk("reset pc", if_pc, 32'h0);
    chk("reset instr", if_instr, 32'h0);
    chk("reset addr", imem_addr, 32'h0);
    chk("reset wrap addr", w_imem_addr, 32'h3FFF_FFFE);

    // Wrap-around
    w_rst_n = 1'b1; w_if_ready = 1'b1;
    q1.push_back(pkt(32'hFFFF_FFF8, 32'hC0DE_000E));
    q1.push_back(pkt(32'hFFFF_FFFC, 32'hC0DE_000F));
    q1.push_back(pkt(32'h0000_0000, 32'hC0DE_0000));
    #1 chk("wrap addr c0", w_imem_addr, 32'h3FFF_FFFE);
    step(); chk("wrap addr c1", w_imem_addr, 32'h3FFF_FFFF);
    step(); chk("wrap addr c2", w_imem_addr, 32'h0000_0000);
    chk("wrap valid c2", {31'b0, w_if_valid}, 32'h1);
    step(); step();
    step(); w_if_ready = 1'b0; w_rst_n = 1'b0;

    // Pipelined fetch
    rst_n = 1'b1; if_ready = 1'b1;
    q0.push_back(pkt(32'h0, 32'h0050_0093));
    q0.push_back(pkt(32'h4, 32'h00A0_0113));
    q0.push_back(pkt(32'h8, 32'h0020_81B3));
    q0.push_back(pkt(32'hC, 32'hDEAD_BEEF));
    #1 chk("fetch addr c0", imem_addr, 32'h0);
    chk("fetch valid c0", {31'b0, if_valid}, 32'h0);
    step(); chk("fetch valid c1", {31'b0, if_valid}, 32'h0);
    step(); chk("fetch valid c2", {31'b0, if_valid}, 32'h1);
    step(); step(); step();
    step(); if_ready = 1'b0;
    step();
    step(); #1 chk("full valid", {31'b0, if_valid}, 32'h1);
    chk("full head pc", if_pc, 32'h10);

    // Mid-stream reset with a full buffer
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1; if_ready = 1'b1;
    #1 chk("mid reset valid", {31'b0, if_valid}, 32'h0);
    chk("mid reset pc", if_pc, 32'h0);
    chk("mid reset instr", if_instr, 32'h0);
    chk("mid reset addr", imem_addr, 32'h0);
    q0.push_back(pkt(32'h0, 32'h0050_0093));
    q0.push_back(pkt(32'h4, 32'h00A0_0113));
    q0.push_back(pkt(32'h8, 32'h0020_81B3));
    q0.push_back(pkt(32'hC, 32'hDEAD_BEEF));
    step(); chk("restart valid c1", {31'b0, if_valid}, 32'h0);
    step(); chk("restart valid c2", {31'b0, if_valid}, 32'h1);
    chk("restart pc c2", if_pc, 32'h0);

    // Backpressure on pc 4
    for (int i = 0; i < 3; i++) begin
      step(); if_ready = 1'b0;
      #1 chk("hold pc", if_pc, 32'h4);
      chk("hold instr", if_instr, 32'h00A0_0113);
      chk("hold valid", {31'b0, if_valid}, 32'h1);
    end
    step(); if_ready = 1'b1;
    step(); chk("release pc8", if_pc, 32'h8);
    step(); chk("release pcC", if_pc, 32'hC);
    step(); if_ready = 1'b0;

    // Redirect while pc 4 is accepted
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1; if_ready = 1'b1;
    q0.push_back(pkt(32'h0, 32'h0050_0093));
    q0.push_back(pkt(32'h4, 32'h00A0_0113));
    q0.push_back(pkt(32'h10, 32'h1234_5678));
    step(); step();
    step(); redirect_valid = 1'b1; redirect_pc = 32'h10;
    #1 chk("redir head pc", if_pc, 32'h4);
    chk("redir addr", imem_addr, 32'h4);
    step(); redirect_valid = 1'b0;
    #1 chk("redir flushed valid", {31'b0, if_valid}, 32'h0);
    step(); chk("redir target valid", {31'b0, if_valid}, 32'h1);

    // Misaligned redirect under backpressure
    step(); if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h13;
    #1 chk("misaligned addr", imem_addr, 32'h4);
    step(); redirect_valid = 1'b0;
    #1 chk("misaligned flushed", {31'b0, if_valid}, 32'h0);
    step(); q0.push_back(pkt(32'h10, 32'h1234_5678)); if_ready = 1'b1;
    #1 chk("misaligned pc", if_pc, 32'h10);

    // Back-to-back redirects: last one wins
    step(); if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0;
    step(); redirect_pc = 32'h8;
    #1 chk("b2b addr", imem_addr, 32'h2);
    step(); redirect_valid = 1'b0;
    #1 chk("b2b flushed", {31'b0, if_valid}, 32'h0);
    step(); q0.push_back(pkt(32'h8, 32'h0020_81B3)); if_ready = 1'b1;
    #1 chk("b2b pc", if_pc, 32'h8);
    step(); if_ready = 1'b0;
    step(); step();

    chk("q0 drained", q0.size(), 32'h0);
    chk("q1 drained", q1.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
